// File: rtl/fm_zc_demod.sv
// Zero-crossing FM demodulator: hysteresis comparator, per-cycle period counter,
// and block averaging of N = 2^AVG_LOG2 periods with deviation from the previous average.
module fm_zc_demod #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int HYST         = 256,
    parameter int AVG_LOG2     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_ce,
    input  logic [SAMPLE_WIDTH-1:0]   i_sample,
    input  logic                      i_clear,
    output logic [PERIOD_WIDTH-1:0]   o_period,
    output logic signed [PERIOD_WIDTH:0] o_deviation,
    output logic                      o_valid,
    output logic                      o_locked,
    output logic                      o_timeout
);

    localparam int ACC_W = PERIOD_WIDTH + AVG_LOG2;
    localparam int EVC_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int N_AVG = 1 << AVG_LOG2;

    localparam logic [PERIOD_WIDTH-1:0]        CNT_MAX  = '1;
    localparam logic [EVC_W-1:0]               EV_LAST  = EVC_W'(N_AVG - 1);
    localparam logic signed [SAMPLE_WIDTH:0]   HYST_POS = (SAMPLE_WIDTH+1)'(HYST);
    localparam logic signed [SAMPLE_WIDTH:0]   HYST_NEG = -HYST_POS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_TRACK
    } state_e;

    state_e                      state_q, state_d;
    logic                        comp_q, comp_d;
    logic [PERIOD_WIDTH-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]            sum_q, sum_d;
    logic [EVC_W-1:0]            evcnt_q, evcnt_d;
    logic [PERIOD_WIDTH-1:0]     period_q, period_d;
    logic signed [PERIOD_WIDTH:0] dev_q, dev_d;
    logic                        valid_q, valid_d;
    logic                        timeout_q, timeout_d;

    // Offset-binary to two's complement is an MSB flip; sign-extend by one bit for compare.
    logic signed [SAMPLE_WIDTH:0] s;
    logic                         above, below, rising;
    logic [PERIOD_WIDTH:0]        measured;
    logic [ACC_W-1:0]             sum_new;
    logic [PERIOD_WIDTH-1:0]      period_new;
    logic signed [PERIOD_WIDTH:0] dev_new;

    assign s      = $signed({~i_sample[SAMPLE_WIDTH-1], ~i_sample[SAMPLE_WIDTH-1],
                             i_sample[SAMPLE_WIDTH-2:0]});
    assign above  = (s >= HYST_POS);
    assign below  = (s <= HYST_NEG);
    assign rising = ~comp_q & above;

    assign measured   = {1'b0, cnt_q} + (PERIOD_WIDTH+1)'(1);
    assign sum_new    = sum_q + ACC_W'(measured);
    assign period_new = PERIOD_WIDTH'(sum_new >> AVG_LOG2);
    assign dev_new    = $signed({1'b0, period_new}) - $signed({1'b0, period_q});

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d   = state_q;
        comp_d    = comp_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        evcnt_d   = evcnt_q;
        period_d  = period_q;
        dev_d     = dev_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (i_clear) begin
            state_d   = ST_IDLE;
            comp_d    = 1'b0;
            cnt_d     = '0;
            sum_d     = '0;
            evcnt_d   = '0;
            timeout_d = 1'b0;
        end else if (i_ce) begin
            if (!comp_q && above) begin
                comp_d = 1'b1;
            end else if (comp_q && below) begin
                comp_d = 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (rising) begin
                        state_d = ST_ACQ;
                        cnt_d   = '0;
                        sum_d   = '0;
                        evcnt_d = '0;
                    end
                end
                ST_ACQ, ST_TRACK: begin
                    if (rising) begin
                        cnt_d = '0;
                        if (evcnt_q == EV_LAST) begin
                            valid_d   = 1'b1;
                            period_d  = period_new;
                            dev_d     = (state_q == ST_TRACK) ? dev_new : '0;
                            sum_d     = '0;
                            evcnt_d   = '0;
                            state_d   = ST_TRACK;
                            timeout_d = 1'b0;
                        end else begin
                            sum_d   = sum_new;
                            evcnt_d = evcnt_q + EVC_W'(1);
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        // Signal lost: drop lock but keep the last published measurement.
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        sum_d     = '0;
                        evcnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + PERIOD_WIDTH'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (reset) begin
            state_q   <= ST_IDLE;
            comp_q    <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            evcnt_q   <= '0;
            period_q  <= '0;
            dev_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            comp_q    <= comp_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            evcnt_q   <= evcnt_d;
            period_q  <= period_d;
            dev_q     <= dev_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_period    = period_q;
    assign o_deviation = dev_q;
    assign o_valid     = valid_q;
    assign o_locked    = (state_q == ST_TRACK);
    assign o_timeout   = timeout_q;

endmodule

// File: doc/fm_zc_demod.md
FM_ZC_DEMOD -- requirements
Module: fm_zc_demod

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, input sample width (offset-binary, midscale 2^(SAMPLE_WIDTH-1)).
REQ-002 SHALL have parameter PERIOD_WIDTH, default 16, period counter and output width.
REQ-003 SHALL have parameter HYST, default 256, comparator hysteresis in LSBs; legal range 1..2^(SAMPLE_WIDTH-1)-1.
REQ-004 SHALL have parameter AVG_LOG2, default 2, where N = 2^AVG_LOG2 periods are averaged per output.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port i_ce, input, 1, sample-valid enable.
REQ-008 SHALL have port i_sample, input, SAMPLE_WIDTH, offset-binary ADC sample.
REQ-009 SHALL have port i_clear, input, 1, synchronous re-acquire request.
REQ-010 SHALL have port o_period, output, PERIOD_WIDTH, averaged period in samples.
REQ-011 SHALL have port o_deviation, output, signed PERIOD_WIDTH+1, new average minus previous average.
REQ-012 SHALL have port o_valid, output, 1, one-cycle strobe marking new o_period/o_deviation.
REQ-013 SHALL have port o_locked, output, 1, high in TRACK.
REQ-014 SHALL have port o_timeout, output, 1, sticky flag set on period-counter saturation.

Function
REQ-015 SHALL form signed s = i_sample - 2^(SAMPLE_WIDTH-1).
REQ-016 SHALL update the comparator only on i_ce cycles: LOW->HIGH when s >= +HYST; HIGH->LOW when s <= -HYST; otherwise hold (s = 0 never changes state).
REQ-017 SHALL define a rising event as a LOW->HIGH transition on an i_ce cycle.
REQ-018 SHALL run the counter on i_ce cycles only: cleared to 0 on a rising event, otherwise +1, saturating at 2^PERIOD_WIDTH-1; measured period = counter+1 at the event.
REQ-019 SHALL implement FSM states IDLE, ACQ and TRACK.
REQ-020 In IDLE, a rising event SHALL start the counter, clear the accumulator and go to ACQ, with no period emitted.
REQ-021 In ACQ/TRACK, each rising event SHALL add the measured period to an accumulator of width PERIOD_WIDTH+AVG_LOG2 and increment an event count.
REQ-022 On the Nth period of a block, the block SHALL assert o_valid, load o_period = (sum incl. Nth) >> AVG_LOG2 (truncate), clear sum and count; ACQ->TRACK.
REQ-023 SHALL set o_deviation = o_period_new - o_period_prev in TRACK, and 0 on the ACQ->TRACK output.
REQ-024 SHALL assert o_valid exactly one clk cycle, on the cycle after the i_ce cycle carrying the completing event; i_ce low cycles SHALL change no state.
REQ-025 If the counter equals 2^PERIOD_WIDTH-1 on an i_ce cycle without a rising event, the block SHALL set o_timeout, go to IDLE, clear sum and count, and drop o_locked; o_period and o_deviation hold.
REQ-026 A rising event coincident with saturation SHALL take priority and no timeout SHALL be raised.
REQ-027 o_timeout SHALL clear only on reset, i_clear, or the next o_valid.
REQ-028 i_clear SHALL force IDLE with comparator LOW, counter, sum and count cleared, and o_locked and o_timeout at 0; o_period and o_deviation hold and no o_valid is produced.
REQ-029 reset SHALL have priority over i_clear, and i_clear SHALL have priority over i_ce activity in the same cycle.

Reset
REQ-030 On reset the block SHALL set FSM to IDLE, comparator LOW, and counter, sum, count, o_period, o_deviation, o_valid, o_locked and o_timeout all 0.
REQ-031 Reset asserted mid-block SHALL discard partial sums; the first o_valid after release SHALL require N+1 rising events.

Verification (bench params PERIOD_WIDTH=8, HYST=256, AVG_LOG2=2)
REQ-032 The bench SHALL hold reset for 2 cycles -> all outputs 0, o_locked 0.
REQ-033 The bench SHALL drive i_ce=1 with 8 samples 0xC000 then 8 samples 0x4000 repeating -> after 5th rising event o_valid once, o_period=16, o_deviation=0, o_locked=1.
REQ-034 The bench SHALL, at a block boundary, switch to 10/10 high/low -> next o_valid o_period=20, o_deviation=+4.
REQ-035 The bench SHALL, after lock, drive samples alternating 0x8064/0x7F9C (inside hysteresis) -> no events; o_timeout=1, o_locked=0 after 255 samples; o_period holds 16/20.
REQ-036 The bench SHALL pulse i_clear after 3 events in ACQ -> no o_valid until 5 further events, then o_period correct.
REQ-037 The bench SHALL repeat REQ-033 with i_ce high every other clk -> identical o_period=16, o_valid one clk wide.
